jtag_scan_master: RTL and testbench

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

---
 rtl/jtag_master_pkg.sv | 28 ++
 rtl/jtag_tck_gen.sv | 44 ++++
 rtl/jtag_scan_master.sv | 137 +++++++++++++
 tb/tb_jtag_scan_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_master_pkg.sv
// Shared constants and encodings for the JTAG scan master.
package jtag_master_pkg;

  localparam int unsigned JTAG_MAX_LEN = 64;
  localparam int unsigned JTAG_LEN_W   = 7;
  localparam int unsigned TLR_PERIODS  = 6;

  typedef enum logic [1:0] {
    CMD_DR  = 2'd0,
    CMD_IR  = 2'd1,
    CMD_RST = 2'd2,
    CMD_RSV = 2'd3
  } jtag_cmd_e;

  // Each non-idle state names the TAP state the target occupies during that TCK period.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_SEL_IR,
    ST_CAPTURE,
    ST_SHIFT,
    ST_EXIT1,
    ST_UPDATE
  } jtag_state_e;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: alternating fall/rise ticks every TCK_HALF clks while enabled; TCK low when idle.
module jtag_tck_gen #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_fall,
  output logic o_rise
);

  localparam logic [7:0] LAST = 8'(TCK_HALF - 1);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic       r_tck;
  logic       w_tick;

  assign w_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tck   <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_tck   <= 1'b0;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= !r_phase;
      r_tck   <= r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_fall = w_tick && !r_phase;
  assign o_rise = w_tick && r_phase;
  assign o_tck  = r_tck;

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: DR/IR scans and TAP reset driven over TCK/TMS/TDI, TDO captured LSB first.
module jtag_scan_master
  import jtag_master_pkg::*;
#(
  parameter int unsigned TCK_HALF = 2,
  parameter int unsigned MAX_LEN  = JTAG_MAX_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [JTAG_LEN_W-1:0] len,
  input  logic [MAX_LEN-1:0]    data_in,
  output logic                  busy,
  output logic                  done,
  output logic [MAX_LEN-1:0]    data_out,
  output logic                  tck,
  output logic                  tms,
  output logic                  tdi,
  input  logic                  tdo
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  jtag_state_e        r_state, w_next;
  logic               r_boot, r_ir, r_done, r_tms, r_tdi;
  logic [IDX_W-1:0]   r_bit, r_last;
  logic [2:0]         r_tlr;
  logic [MAX_LEN-1:0] r_din, r_dout;
  logic               w_busy, w_fall, w_rise, w_accept, w_accept_rst;
  logic               w_tms, w_tdi, w_shift_last, w_tlr_last, w_end;

  jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_busy),
    .o_tck  (tck),
    .o_fall (w_fall),
    .o_rise (w_rise)
  );

  // r_boot forces a TAP reset as the first command after every reset release.
  assign w_busy       = (r_state != ST_IDLE);
  assign w_accept_rst = r_boot || cmd[1];
  assign w_accept     = !w_busy && (r_boot || (start && (cmd[1] || (len != '0))));
  assign w_shift_last = (r_bit == r_last);
  assign w_tlr_last   = (r_tlr == 3'(TLR_PERIODS - 1));
  assign w_end        = w_rise && (((r_state == ST_TLR) && w_tlr_last) || (r_state == ST_UPDATE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // States advance on rise ticks; the TMS/TDI chosen here are registered on the next fall tick.
  always_comb begin
    w_next = r_state;
    w_tms  = 1'b0;
    w_tdi  = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = w_accept_rst ? ST_TLR : ST_RTI;
      ST_TLR: begin
        w_tms = !w_tlr_last;
        if (w_rise && w_tlr_last) w_next = ST_IDLE;
      end
      ST_RTI: begin
        w_tms = 1'b1;
        if (w_rise) w_next = ST_SEL_DR;
      end
      ST_SEL_DR: begin
        w_tms = r_ir;
        if (w_rise) w_next = r_ir ? ST_SEL_IR : ST_CAPTURE;
      end
      ST_SEL_IR:  if (w_rise) w_next = ST_CAPTURE;
      ST_CAPTURE: if (w_rise) w_next = ST_SHIFT;
      ST_SHIFT: begin
        w_tms = w_shift_last;
        w_tdi = r_din[r_bit];
        if (w_rise && w_shift_last) w_next = ST_EXIT1;
      end
      ST_EXIT1: begin
        w_tms = 1'b1;
        if (w_rise) w_next = ST_UPDATE;
      end
      ST_UPDATE:  if (w_rise) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boot <= 1'b1;
      r_ir   <= 1'b0;
      r_done <= 1'b0;
      r_tms  <= 1'b1;
      r_tdi  <= 1'b0;
      r_bit  <= '0;
      r_last <= '0;
      r_tlr  <= '0;
      r_din  <= '0;
      r_dout <= '0;
    end else begin
      r_done <= w_end;
      if (w_accept) begin
        r_boot <= 1'b0;
        r_ir   <= !w_accept_rst && (cmd == CMD_IR);
        r_last <= IDX_W'(len - 1'b1);
        r_din  <= data_in;
        r_dout <= '0;
        r_bit  <= '0;
        r_tlr  <= '0;
      end
      if (w_fall) begin
        r_tms <= w_tms;
        r_tdi <= w_tdi;
      end
      if (w_end) begin
        r_tms <= 1'b0;
        r_tdi <= 1'b0;
      end
      if (w_rise) begin
        if (r_state == ST_TLR) r_tlr <= r_tlr + 1'b1;
        if (r_state == ST_SHIFT) begin
          r_dout[r_bit] <= tdo;
          r_bit         <= r_bit + 1'b1;
        end
      end
    end
  end

  assign busy     = w_busy;
  assign done     = r_done;
  assign data_out = r_dout;
  assign tms      = r_tms;
  assign tdi      = r_tdi;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target (IDCODE/BYPASS) plus table, directed and random scans.
module tb_jtag_scan_master;

  localparam logic [31:0] IDCODE = 32'h149511C3;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, tdo = 1'b0;
  logic [1:0]  cmd = '0;
  logic [6:0]  len = '0;
  logic [63:0] data_in = '0;
  logic        busy, done, tck, tms, tdi;
  logic [63:0] data_out;
  int          n_checks = 0, n_err = 0, done_cnt = 0;

  always #5 clk = ~clk;

  jtag_scan_master #(.TCK_HALF(2), .MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .len(len), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // ---------------- target TAP model ----------------
  typedef enum int {T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR, T_UDR,
                    T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR} tap_e;
  tap_e        t_st = T_SHDR;
  logic [7:0]  t_ir = 8'h02, t_irsh = 8'h00;
  logic [63:0] t_dr = '0;
  int          t_w = 1;

  function automatic tap_e tap_next(tap_e s, logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (t_st)
      T_TLR:  t_ir <= 8'h02;
      T_CIR:  t_irsh <= 8'h01;
      T_SHIR: t_irsh <= {tdi, t_irsh[7:1]};
      T_UIR:  t_ir <= t_irsh;
      T_CDR: begin
        if (t_ir == 8'h02) begin t_dr <= {32'h0, IDCODE}; t_w <= 32; end
        else begin t_dr <= '0; t_w <= 1; end
      end
      T_SHDR: t_dr <= (t_dr >> 1) | (64'(tdi) << (t_w - 1));
      default: ;
    endcase
    t_st <= tap_next(t_st, tms);
  end

  always @(negedge tck)
    tdo <= (t_st == T_SHDR) ? t_dr[0] : ((t_st == T_SHIR) ? t_irsh[0] : 1'b0);

  logic q_tms[$], q_tdi[$];
  always @(posedge tck) begin
    q_tms.push_back(tms);
    q_tdi.push_back(tdi);
  end
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // ---------------- reference model ----------------
  logic [7:0] m_ir = 8'h02;

  function automatic logic [127:0] lmask(int l);
    return (128'd1 << l) - 128'd1;
  endfunction

  function automatic int exp_periods(logic [1:0] c, int l);
    if (c[1]) return 6;
    return l + ((c == 2'd1) ? 6 : 5);
  endfunction

  function automatic logic [127:0] exp_tms(logic [1:0] c, int l);
    logic [127:0] v = '0;
    int n = exp_periods(c, l);
    int pre = (c == 2'd1) ? 4 : 3;
    for (int k = 0; k < n; k++) begin
      if (c[1])                v[k] = (k < 5);
      else if (k < pre)        v[k] = (k == 0) || ((c == 2'd1) && (k == 1));
      else if (k < pre + l - 1) v[k] = 1'b0;
      else                     v[k] = (k < n - 1);
    end
    return v;
  endfunction

  function automatic logic [63:0] model_out(logic [1:0] c, int l, logic [63:0] d);
    logic [127:0] s;
    if (c[1]) return '0;
    if (c == 2'd1)          s = 128'h01 | ({64'h0, d} << 8);
    else if (m_ir == 8'h02) s = {96'h0, IDCODE} | ({64'h0, d} << 32);
    else                    s = {64'h0, d} << 1;
    s = s & lmask(l);
    return s[63:0];
  endfunction

  task automatic model_update(input logic [1:0] c, input int l, input logic [63:0] d);
    logic [127:0] s;
    if (c[1]) m_ir = 8'h02;
    else if (c == 2'd1) begin
      s = (128'h01 | ({64'h0, d} << 8)) >> l;
      m_ir = s[7:0];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [1:0] c, input int l, input logic [63:0] d);
    @(negedge clk);
    q_tms.delete();
    q_tdi.delete();
    cmd = c; len = 7'(l); data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic post_chk(input string tag, input logic [1:0] c, input int l, input logic [63:0] d,
                          input logic [63:0] eo, input int ep, input logic ok);
    logic [127:0] gt = '0, gd = '0;
    int pre = (c == 2'd1) ? 4 : 3;
    for (int i = 0; i < q_tms.size() && i < 128; i++) gt[i] = q_tms[i];
    if (c[1]) for (int i = 0; i < q_tdi.size() && i < 128; i++) gd[i] = q_tdi[i];
    else      for (int i = 0; i < l; i++) if (pre + i < q_tdi.size()) gd[i] = q_tdi[pre + i];
    chk({tag, "_done"}, 128'(ok), 128'd1);
    chk({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    chk({tag, "_data_out"}, 128'(data_out), 128'(eo));
    chk({tag, "_periods"}, 128'(q_tms.size()), 128'(ep));
    chk({tag, "_tms_seq"}, gt, exp_tms(c, l));
    chk({tag, "_tdi_bits"}, gd, c[1] ? 128'd0 : (128'(d) & lmask(l)));
    chk({tag, "_tap_in_rti"}, 128'(t_st), 128'(T_RTI));
    @(negedge clk);
    chk({tag, "_done_width"}, 128'(done), 128'd0);
  endtask

  task automatic scan_chk(input string tag, input logic [1:0] c, input int l, input logic [63:0] d,
                          input logic [63:0] eo, input int ep);
    logic ok;
    start_cmd(c, l, d);
    chk({tag, "_busy_rise"}, 128'(busy), 128'd1);
    wait_done(ok);
    post_chk(tag, c, l, d, eo, ep, ok);
    model_update(c, l, d);
  endtask

  typedef struct {
    logic [1:0]  c;
    int          l;
    logic [63:0] d;
    logic [63:0] eo;
    int          ep;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic        ok, busy_seen;
    logic [63:0] d;
    logic [1:0]  c;
    int          l, n0;

    tbl[0] = '{2'd1,  8, 64'h02,               64'h01,               14};
    tbl[1] = '{2'd0, 32, 64'h0,                64'h149511C3,         37};
    tbl[2] = '{2'd0,  1, 64'h0,                64'h1,                 6};
    tbl[3] = '{2'd1,  8, 64'hFF,               64'h01,               14};
    tbl[4] = '{2'd0,  8, 64'hA5,               64'h4A,               13};
    tbl[5] = '{2'd2,  0, 64'h0,                64'h0,                 6};
    tbl[6] = '{2'd0, 64, 64'h0123456789ABCDEF, 64'h89ABCDEF149511C3, 69};
    tbl[7] = '{2'd3,  5, 64'hFFFF,             64'h0,                 6};
    tbl[8] = '{2'd1,  4, 64'hF,                64'h1,                10};
    tbl[9] = '{2'd0, 16, 64'h1234,             64'h2468,             21};

    // reset values, then the automatic TAP reset
    repeat (3) @(negedge clk);
    chk("rst_pins", 128'({tck, tms, tdi, busy, done}), 128'(5'b01000));
    chk("rst_data_out", 128'(data_out), 128'd0);
    q_tms.delete();
    q_tdi.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("boot_busy", 128'(busy), 128'd1);
    wait_done(ok);
    post_chk("boot", 2'd2, 0, 64'h0, 64'h0, 6, ok);
    model_update(2'd2, 0, 64'h0);

    for (int i = 0; i < 10; i++)
      scan_chk($sformatf("vec%0d", i), tbl[i].c, tbl[i].l, tbl[i].d, tbl[i].eo, tbl[i].ep);

    // start while busy and data_in changes mid-scan are ignored
    d = 64'hBEEF;
    n0 = done_cnt;
    start_cmd(2'd0, 16, d);
    repeat (20) @(negedge clk);
    start = 1'b1; cmd = 2'd1; len = 7'd8; data_in = '1;
    @(negedge clk);
    start = 1'b0; data_in = {$urandom, $urandom};
    wait_done(ok);
    post_chk("inflight", 2'd0, 16, d, model_out(2'd0, 16, d), 21, ok);
    chk("inflight_done_count", 128'(done_cnt - n0), 128'd1);
    model_update(2'd0, 16, d);

    // len=0 scan start is ignored
    n0 = done_cnt;
    busy_seen = 1'b0;
    start_cmd(2'd0, 0, 64'hFFFF);
    repeat (60) begin @(negedge clk); busy_seen |= busy; end
    chk("len0_busy", 128'(busy_seen), 128'd0);
    chk("len0_done_count", 128'(done_cnt - n0), 128'd0);
    chk("len0_no_tck", 128'(q_tms.size()), 128'd0);
    chk("len0_data_held", 128'(data_out), 128'h7DDE);

    // reset mid-shift
    start_cmd(2'd0, 32, {$urandom, $urandom});
    for (int i = 0; i < 2000 && q_tms.size() < 10; i++) @(negedge clk);
    chk("midrst_reached_shift", 128'(q_tms.size() >= 10), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pins", 128'({tck, tms, tdi, busy, done}), 128'(5'b01000));
    chk("midrst_data_out", 128'(data_out), 128'd0);
    n0 = done_cnt;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - n0), 128'd0);
    q_tms.delete();
    q_tdi.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'd1);
    wait_done(ok);
    post_chk("midrst_boot", 2'd2, 0, 64'h0, 64'h0, 6, ok);
    model_update(2'd2, 0, 64'h0);

    // randomized scans against the model
    for (int i = 0; i < 24; i++) begin
      int r = $urandom_range(0, 9);
      d = {$urandom, $urandom};
      if (r < 6) begin
        c = 2'd0;
        l = $urandom_range(1, 64);
      end else if (r < 8) begin
        int sel = $urandom_range(0, 2);
        c = 2'd1;
        l = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 8;
        if (sel == 0) d = 64'h02;
        else if (sel == 1) d = 64'hFF;
      end else begin
        c = (r == 8) ? 2'd2 : 2'd3;
        l = $urandom_range(0, 64);
      end
      scan_chk($sformatf("rnd%0d", i), c, l, d, model_out(c, l, d), exp_periods(c, l));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
